rgb_bit_serializer: RTL and testbench
=====================================

Name: rgb_bit_serializer

Overview:
- Upstream feeder for the serial greyscale/threshold stage.
- Accepts parallel 8-bit R/G/B pixels over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each pixel out as three parallel 1-bit streams (pred/pgreen/pblue), LSB first, in fixed 8-cycle words.
- Keeps word framing unbroken while running: on FIFO underrun it emits an all-zero pixel.

Parameters:
- DEPTH, 4, FIFO depth in pixels; power of two, minimum 2.
- CW, 16, width of the underrun counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  start/stop serial output.
- pix_valid  input  1  upstream pixel valid.
- pix_ready  output  1  FIFO can accept a pixel.
- pix_r  input  8  red component.
- pix_g  input  8  green component.
- pix_b  input  8  blue component.
- pred  output  1  serial red bit.
- pgreen  output  1  serial green bit.
- pblue  output  1  serial blue bit.
- bit_idx  output  3  index of the bit currently on pred/pgreen/pblue.
- frame_start  output  1  high while bit_idx==0 in RUN/DRAIN.
- busy  output  1  state != IDLE.
- fifo_level  output  $clog2(DEPTH)+1  pixels held in the FIFO.
- underrun_cnt  output  CW  count of zero words emitted; saturates at all-ones.

Behaviour:
- Reset (async, rst_n low) clears the following immediately, independent of clk:
  - state to IDLE; FIFO emptied (pointers 0, fifo_level 0); shift registers 0.
  - outputs: pred/pgreen/pblue 0, bit_idx 0, frame_start 0, busy 0, underrun_cnt 0.
  - pix_ready is driven 0 while rst_n is low, then 1 from the first edge after release.
- FIFO:
  - pix_ready = !full (registered level, not combinational on pop). A push occurs on any edge where pix_valid && pix_ready.
  - When full, pushes are refused even if a pop happens on the same edge.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_level unchanged.
  - A push into an empty FIFO is poppable from the next edge onward (one-cycle latency).
- Word load ("load event"):
  - If the FIFO is non-empty: pop the head into the R/G/B shift registers.
  - If the FIFO is empty: load 0/0/0 and increment underrun_cnt, saturating.
- Serial output:
  - pred/pgreen/pblue = bit 0 of each shift register.
  - Each subsequent edge shifts right by one, so bit k of the pixel is presented while bit_idx==k.
  - Outputs change only on the rising edge, so they are stable for falling-edge sampling by the consumer.
- State machine:
  - IDLE: outputs 0, bit_idx 0. If enable is high at an edge: load event, go to RUN, bit_idx 0.
  - RUN: bit_idx increments every edge, wrapping 7 to 0.
    - On the edge where bit_idx==7: if enable is high, load event and stay in RUN.
    - If enable is low on that edge: go to IDLE, with no load and no pop.
    - If enable falls mid-word: go to DRAIN.
  - DRAIN: finish the current word (bit_idx continues to 7), then go to IDLE with no load.
    - If enable rises again before bit_idx==7, return to RUN; the word boundary is unaffected.
- Word framing: exactly 8 cycles per word, from entry into RUN until return to IDLE. Words are never shortened or stretched.
- underrun_cnt is counted only in RUN, including the initial load from IDLE. It is not cleared by enable; only reset clears it.
- Reset mid-word: the word is discarded and the next word starts with bit_idx 0 after enable.

Test Plan:
- Single pixel:
  - Stimulus: push R=0xA5, G=0x3C, B=0xFF, then raise enable.
  - Required: pred sequence bit_idx0..7 = 1,0,1,0,0,1,0,1; pgreen = 0,0,1,1,1,1,0,0; pblue all 1; frame_start high on the first cycle only.
  - Hold enable: next word is zeros and underrun_cnt = 1.
- Back-to-back:
  - Stimulus: stream 10 pixels with pix_valid held high and enable high.
  - Required: 80 consecutive serial cycles with no gaps; underrun_cnt stays 0 after the first load succeeds.
  - pix_ready drops once fifo_level == DEPTH and never accepts a push while full.
- Underrun:
  - Stimulus: enable high with an empty FIFO for 3 words, then push 0x01/0x02/0x04.
  - Required: 24 zero cycles with underrun_cnt = 3, then pred=1 at bit_idx0, pgreen=1 at bit_idx1, pblue=1 at bit_idx2 on the next word boundary.
- Enable drop mid-word:
  - Stimulus: drop enable at bit_idx 3.
  - Required: state DRAIN; bits 4..7 still emitted; busy falls after bit_idx 7; no FIFO pop (fifo_level unchanged).
- Async reset:
  - Stimulus: assert rst_n low at bit_idx 5 with 3 pixels queued.
  - Required: outputs 0 and fifo_level 0 immediately, without waiting for a clock.
  - After release with enable high: the first word is zero and underrun_cnt = 1.
- Saturation:
  - Stimulus: force CW=4 and run 20 empty words.
  - Required: underrun_cnt = 15 and holds at 15.

Source files
------------

// File: rtl/rgb_bit_serializer.sv
// rgb_bit_serializer: buffers parallel RGB pixels in a small FIFO and shifts them out
// LSB-first as three 1-bit streams in fixed 8-cycle words, zero-filling on underrun.
module rgb_bit_serializer #(
   parameter int DEPTH = 4,
   parameter int CW    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   pix_valid,
   output logic                   pix_ready,
   input  logic [7:0]             pix_r,
   input  logic [7:0]             pix_g,
   input  logic [7:0]             pix_b,
   output logic                   pred,
   output logic                   pgreen,
   output logic                   pblue,
   output logic [2:0]             bit_idx,
   output logic                   frame_start,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [CW-1:0]          underrun_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
   localparam logic [LW-1:0] PTR_ONE    = LW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    bit_nxt;
   logic          load;

   logic [23:0]   mem [DEPTH];
   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [LW-1:0] level_nxt;
   logic          empty;
   logic          push;
   logic          pop;
   logic          ready_q;
   logic [23:0]   head;

   logic [7:0]    sr_r;
   logic [7:0]    sr_g;
   logic [7:0]    sr_b;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level     = wr_ptr - rd_ptr;
   assign empty     = (level == '0);
   assign push      = pix_valid && ready_q;
   assign pop       = load && !empty;
   assign level_nxt = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign head      = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         ready_q <= (level_nxt != FULL_LEVEL);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {pix_r, pix_g, pix_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_idx <= 3'd0;
      end else begin
         state   <= state_nxt;
         bit_idx <= bit_nxt;
      end
   end

   // A word always runs its full 8 bits; enable is only honoured at the bit-7 boundary.
   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_idx;
      load      = 1'b0;
      case (state)
         IDLE: begin
            bit_nxt = 3'd0;
            if (enable) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            bit_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
               if (enable) load = 1'b1;
               else        state_nxt = IDLE;
            end else if (!enable) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            bit_nxt = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_nxt = IDLE;
            else if (enable)     state_nxt = RUN;
         end
         default: begin
            state_nxt = IDLE;
            bit_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_r <= 8'd0;
         sr_g <= 8'd0;
         sr_b <= 8'd0;
      end else if (load) begin
         if (empty) begin
            sr_r <= 8'd0;
            sr_g <= 8'd0;
            sr_b <= 8'd0;
         end else begin
            {sr_r, sr_g, sr_b} <= head;
         end
      end else if (state_nxt == IDLE) begin
         sr_r <= 8'd0;
         sr_g <= 8'd0;
         sr_b <= 8'd0;
      end else begin
         sr_r <= sr_r >> 1;
         sr_g <= sr_g >> 1;
         sr_b <= sr_b >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
      end else if (load && empty && (underrun_cnt != '1)) begin
         underrun_cnt <= underrun_cnt + CNT_ONE;
      end
   end

   assign pred        = sr_r[0];
   assign pgreen      = sr_g[0];
   assign pblue       = sr_b[0];
   assign busy        = (state != IDLE);
   assign frame_start = busy && (bit_idx == 3'd0);
   assign pix_ready   = ready_q;
   assign fifo_level  = level;

endmodule

// File: tb/tb_rgb_bit_serializer.sv
// tb_rgb_bit_serializer: randomized and directed checks of rgb_bit_serializer against a
// word-level queue model of the pixel stream.
module tb_rgb_bit_serializer;

   localparam int DEPTH = 4;
   localparam int CW    = 16;
   localparam int UMAX  = (1 << CW) - 1;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;
   logic        pred;
   logic        pgreen;
   logic        pblue;
   logic [2:0]  bit_idx;
   logic        frame_start;
   logic        busy;
   logic [2:0]  fifo_level;
   logic [15:0] underrun_cnt;

   logic        sat_rst_n;
   logic        sat_en;
   logic        sat_pix_ready;
   logic        sat_pred;
   logic        sat_pgreen;
   logic        sat_pblue;
   logic [2:0]  sat_bit_idx;
   logic        sat_frame_start;
   logic        sat_busy;
   logic [1:0]  sat_level;
   logic [3:0]  sat_cnt;

   int n_tests;
   int n_fail;

   logic [23:0] m_q[$];
   bit          m_active;
   bit          m_draining;
   bit          m_ready;
   bit          m_pushed;
   int          m_pos;
   int          m_under;
   logic [23:0] m_word;

   logic [27:0] dut_all;

   rgb_bit_serializer #(.DEPTH(DEPTH), .CW(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .pred(pred), .pgreen(pgreen), .pblue(pblue),
      .bit_idx(bit_idx), .frame_start(frame_start), .busy(busy),
      .fifo_level(fifo_level), .underrun_cnt(underrun_cnt)
   );

   rgb_bit_serializer #(.DEPTH(2), .CW(4)) u_sat (
      .clk(clk), .rst_n(sat_rst_n), .enable(sat_en),
      .pix_valid(1'b0), .pix_ready(sat_pix_ready),
      .pix_r(8'h00), .pix_g(8'h00), .pix_b(8'h00),
      .pred(sat_pred), .pgreen(sat_pgreen), .pblue(sat_pblue),
      .bit_idx(sat_bit_idx), .frame_start(sat_frame_start), .busy(sat_busy),
      .fifo_level(sat_level), .underrun_cnt(sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dut_all = {pred, pgreen, pblue, bit_idx, frame_start, busy,
                     pix_ready, fifo_level, underrun_cnt};

   task automatic model_reset();
      m_q.delete();
      m_active   = 1'b0;
      m_draining = 1'b0;
      m_ready    = 1'b0;
      m_pushed   = 1'b0;
      m_pos      = 0;
      m_under    = 0;
      m_word     = 24'h0;
   endtask

   task automatic start_word();
      m_active   = 1'b1;
      m_draining = 1'b0;
      m_pos      = 0;
      if (m_q.size() > 0) begin
         m_word = m_q.pop_front();
      end else begin
         m_word = 24'h0;
         if (m_under < UMAX) m_under++;
      end
   endtask

   // One clock edge of the stream: words begin only at a boundary, and a pixel
   // pushed on this edge can only be popped on a later one.
   task automatic model_edge();
      bit          do_push;
      logic [23:0] in_pix;
      if (!rst_n) begin
         model_reset();
         return;
      end
      do_push = pix_valid && m_ready;
      in_pix  = {pix_r, pix_g, pix_b};
      if (!m_active) begin
         if (enable) start_word();
      end else if (m_pos == 7) begin
         if (enable && !m_draining) start_word();
         else                       m_active = 1'b0;
      end else begin
         m_pos++;
         m_draining = !enable;
      end
      if (do_push) m_q.push_back(in_pix);
      m_pushed = do_push;
      m_ready  = (m_q.size() < DEPTH);
   endtask

   function automatic logic [27:0] model_all();
      logic r, g, b;
      r = m_active ? m_word[16 + m_pos] : 1'b0;
      g = m_active ? m_word[8 + m_pos]  : 1'b0;
      b = m_active ? m_word[m_pos]      : 1'b0;
      return {r, g, b, (m_active ? 3'(m_pos) : 3'd0), (m_active && m_pos == 0),
              m_active, m_ready, 3'(m_q.size()), 16'(m_under)};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if (dut_all !== model_all()) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got %h expected %h", dut_all, model_all());
      end
      n_tests++;
      if (pix_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ready_low: got %b expected 0", pix_ready);
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (dut_all !== model_all()) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got %h expected %h", dut_all, model_all());
      end
      n_tests++;
      if (pix_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_ready_high: got %b expected 1", pix_ready);
      end
   endtask

   task automatic test_single_pixel();
      logic [7:0] er;
      logic [7:0] eg;
      er = 8'hA5;
      eg = 8'h3C;
      pix_valid = 1'b1;
      pix_r = 8'hA5; pix_g = 8'h3C; pix_b = 8'hFF;
      tick();
      pix_valid = 1'b0;
      n_tests++;
      if (fifo_level !== 3'd1) begin
         n_fail++;
         $display("[TB] FAIL single_level: got %0d expected 1", fifo_level);
      end
      enable = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         n_tests++;
         if (dut_all !== model_all()) begin
            n_fail++;
            $display("[TB] FAIL single_model k=%0d: got %h expected %h", k, dut_all, model_all());
         end
         if (k < 8) begin
            n_tests++;
            if ({pred, pgreen, pblue, frame_start} !== {er[k], eg[k], 1'b1, (k == 0)}) begin
               n_fail++;
               $display("[TB] FAIL single_bits k=%0d: got %b expected %b", k,
                        {pred, pgreen, pblue, frame_start}, {er[k], eg[k], 1'b1, (k == 0)});
            end
         end else begin
            n_tests++;
            if ({pred, pgreen, pblue, underrun_cnt} !== {3'b000, 16'd1}) begin
               n_fail++;
               $display("[TB] FAIL single_zero_word k=%0d: got %b/%0d expected 000/1", k,
                        {pred, pgreen, pblue}, underrun_cnt);
            end
         end
      end
      enable = 1'b0;
      tick();
      n_tests++;
      if (dut_all !== model_all()) begin
         n_fail++;
         $display("[TB] FAIL single_stop: got %h expected %h", dut_all, model_all());
      end
   endtask

   task automatic test_underrun();
      int base;
      base   = m_under;
      enable = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         tick();
         n_tests++;
         if (dut_all !== model_all() || {pred, pgreen, pblue} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL underrun_zero i=%0d: got %h expected %h", i, dut_all, model_all());
         end
         if (i == 20) begin
            pix_valid = 1'b1;
            pix_r = 8'h01; pix_g = 8'h02; pix_b = 8'h04;
         end
         if (i == 21) pix_valid = 1'b0;
      end
      n_tests++;
      if (underrun_cnt !== 16'(base + 3)) begin
         n_fail++;
         $display("[TB] FAIL underrun_count: got %0d expected %0d", underrun_cnt, base + 3);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         n_tests++;
         if (dut_all !== model_all() || {pred, pgreen, pblue} !== {(k == 0), (k == 1), (k == 2)}) begin
            n_fail++;
            $display("[TB] FAIL underrun_recover k=%0d: got %h expected %h", k, dut_all, model_all());
         end
      end
      enable = 1'b0;
      tick();
      n_tests++;
      if (dut_all !== model_all()) begin
         n_fail++;
         $display("[TB] FAIL underrun_stop: got %h expected %h", dut_all, model_all());
      end
   endtask

   task automatic test_drain();
      int exp_lvl;
      for (int p = 0; p < 3; p++) begin
         pix_valid = 1'b1;
         {pix_r, pix_g, pix_b} = 24'($urandom);
         tick();
      end
      pix_valid = 1'b0;
      enable    = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      enable  = 1'b0;
      exp_lvl = m_q.size();
      for (int k = 4; k < 8; k++) begin
         tick();
         n_tests++;
         if (dut_all !== model_all() || bit_idx !== 3'(k) || busy !== 1'b1 || fifo_level !== 3'(exp_lvl)) begin
            n_fail++;
            $display("[TB] FAIL drain_bits k=%0d: got %h expected %h", k, dut_all, model_all());
         end
      end
      tick();
      n_tests++;
      if (busy !== 1'b0 || fifo_level !== 3'(exp_lvl)) begin
         n_fail++;
         $display("[TB] FAIL drain_end: got busy=%b level=%0d expected busy=0 level=%0d",
                  busy, fifo_level, exp_lvl);
      end
      // Re-enable during a drain: the word keeps its boundary and the next word follows.
      enable = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 2) enable = 1'b0;
         if (k == 3) enable = 1'b1;
         n_tests++;
         if (dut_all !== model_all()) begin
            n_fail++;
            $display("[TB] FAIL drain_resume k=%0d: got %h expected %h", k, dut_all, model_all());
         end
      end
      enable = 1'b0;
      for (int g = 0; g < 10 && m_active; g++) tick();
      n_tests++;
      if (dut_all !== model_all() || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL drain_idle: got %h expected %h", dut_all, model_all());
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] pix [10];
      int          idx;
      int          base;
      for (int i = 0; i < 10; i++) pix[i] = 24'($urandom);
      while (m_q.size() > 0) begin
         enable = 1'b1;
         tick();
      end
      enable = 1'b0;
      for (int g = 0; g < 10 && m_active; g++) tick();
      base      = m_under;
      idx       = 0;
      pix_valid = 1'b1;
      {pix_r, pix_g, pix_b} = pix[0];
      for (int c = 0; c < 82; c++) begin
         if (c == 2) enable = 1'b1;
         tick();
         n_tests++;
         if (dut_all !== model_all() || underrun_cnt !== 16'(base)) begin
            n_fail++;
            $display("[TB] FAIL b2b c=%0d: got %h expected %h", c, dut_all, model_all());
         end
         if (m_pushed) begin
            idx++;
            if (idx < 10) {pix_r, pix_g, pix_b} = pix[idx];
            else          pix_valid = 1'b0;
         end
      end
      enable = 1'b0;
      for (int g = 0; g < 10 && m_active; g++) tick();
      n_tests++;
      if (busy !== 1'b0 || fifo_level !== 3'd0 || idx != 10) begin
         n_fail++;
         $display("[TB] FAIL b2b_end: got busy=%b level=%0d pushed=%0d expected 0/0/10",
                  busy, fifo_level, idx);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         tick();
         n_tests++;
         if (dut_all !== model_all()) begin
            n_fail++;
            $display("[TB] FAIL random c=%0d: got %h expected %h", c, dut_all, model_all());
         end
         if ($urandom_range(0, 7) == 0) enable = ~enable;
         pix_valid = ($urandom_range(0, 3) == 0);
         {pix_r, pix_g, pix_b} = 24'($urandom);
      end
      pix_valid = 1'b0;
      enable    = 1'b0;
      for (int g = 0; g < 10 && m_active; g++) tick();
   endtask

   task automatic test_async_reset();
      for (int p = 0; p < 6 && m_q.size() < 3; p++) begin
         pix_valid = 1'b1;
         {pix_r, pix_g, pix_b} = 24'($urandom) | 24'h010101;
         tick();
      end
      pix_valid = 1'b0;
      enable    = 1'b1;
      for (int g = 0; g < 16 && !(m_active && m_pos == 5); g++) tick();
      n_tests++;
      if (bit_idx !== 3'd5) begin
         n_fail++;
         $display("[TB] FAIL areset_setup: got bit_idx %0d expected 5", bit_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_tests++;
      if (dut_all !== model_all() || fifo_level !== 3'd0) begin
         n_fail++;
         $display("[TB] FAIL areset_immediate: got %h expected %h", dut_all, model_all());
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (dut_all !== model_all() || underrun_cnt !== 16'd1 || busy !== 1'b1 ||
          {pred, pgreen, pblue} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL areset_first_word: got %h expected %h", dut_all, model_all());
      end
      enable = 1'b0;
      for (int g = 0; g < 10 && m_active; g++) tick();
   endtask

   task automatic test_saturation();
      int loads;
      int exp_cnt;
      sat_rst_n = 1'b1;
      sat_en    = 1'b1;
      for (int e = 1; e <= 240; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e % 8 == 0) begin
            loads   = (e - 1) / 8 + 1;
            exp_cnt = (loads > 15) ? 15 : loads;
            n_tests++;
            if (sat_cnt !== 4'(exp_cnt) || sat_busy !== 1'b1) begin
               n_fail++;
               $display("[TB] FAIL saturation e=%0d: got %0d expected %0d", e, sat_cnt, exp_cnt);
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      sat_rst_n = 1'b0;
      sat_en    = 1'b0;
      enable    = 1'b0;
      pix_valid = 1'b0;
      pix_r     = 8'h00;
      pix_g     = 8'h00;
      pix_b     = 8'h00;
      model_reset();
      test_reset();
      test_single_pixel();
      test_underrun();
      test_drain();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
